// File: rtl/wb_ctl_pipe.sv
// Writeback-control pipeline: decodes write-back source / register-write
// enable from each issued RV32I instruction and carries them with rd through
// STAGES registers, exposing per-stage hazard taps and a retire counter.
module wb_ctl_pipe #(
  parameter int STAGES      = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           instruction,
  input  logic                  stall,
  input  logic                  flush,
  output logic [1:0]            wb_sel,
  output logic                  regWEn,
  output logic [4:0]            wb_rd,
  output logic [STAGES-1:0]     hz_we,
  output logic [5*STAGES-1:0]   hz_rd,
  output logic [STAGES-1:0]     hz_load,
  output logic [CNT_W-1:0]      retired
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [1:0] SEL_MEM = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic [1:0] sel;
    logic [4:0] rd;
  } stage_t;

  stage_t              dec;
  stage_t              st_reg [STAGES];
  stage_t              prev   [STAGES];
  logic [STAGES-1:0]   kill;
  logic [CNT_W-1:0]    retired_reg;

  // Upper instruction bits carry immediates/funct fields this block ignores.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[31:12];

  // Decode the issuing instruction into the stage tuple; rd==x0 never writes.
  always_comb begin
    dec     = '0;
    dec.v   = in_valid;
    dec.rd  = instruction[11:7];
    case (instruction[6:0])
      OP_LUI, OP_AUIPC, OP_IMM, OP_OP: begin
        dec.we  = 1'b1;
        dec.sel = SEL_ALU;
      end
      OP_JAL, OP_JALR: begin
        dec.we  = 1'b1;
        dec.sel = SEL_PC4;
      end
      OP_LOAD: begin
        dec.we  = 1'b1;
        dec.ld  = 1'b1;
        dec.sel = SEL_MEM;
      end
      default: begin
        dec.we  = 1'b0;
        dec.sel = SEL_MEM;
      end
    endcase
    if (dec.rd == 5'd0) dec.we = 1'b0;
  end

  // Per-stage source selection, flush kill mask and hazard taps.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign prev[gi] = dec;
      end else begin : g_body
        assign prev[gi] = st_reg[gi-1];
      end
      assign kill[gi]           = flush && (gi < FLUSH_DEPTH);
      assign hz_we[gi]          = st_reg[gi].v & st_reg[gi].we;
      assign hz_load[gi]        = st_reg[gi].v & st_reg[gi].ld;
      assign hz_rd[5*gi +: 5]   = st_reg[gi].rd;
    end
  endgenerate

  // Shift the pipe when not stalled; flush clears valid of the young stages
  // whether or not the pipe moves this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) st_reg[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (!stall) st_reg[i] <= prev[i];
        if (kill[i]) st_reg[i].v <= 1'b0;
      end
    end
  end

  // Count instructions leaving the final stage while valid (wraps freely).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_reg <= '0;
    end else if (!stall && st_reg[STAGES-1].v) begin
      retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign retired = retired_reg;
  assign regWEn  = st_reg[STAGES-1].v & st_reg[STAGES-1].we;
  assign wb_sel  = st_reg[STAGES-1].v ? st_reg[STAGES-1].sel : 2'b00;
  assign wb_rd   = st_reg[STAGES-1].v ? st_reg[STAGES-1].rd  : 5'd0;

endmodule

// File: tb/tb_wb_ctl_pipe.sv
// Self-checking bench for wb_ctl_pipe: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the pipeline.
module tb_wb_ctl_pipe;

  localparam int STG = 3;
  localparam int FD  = 2;
  localparam int CW  = 4;
  localparam int OW  = 8 + 2*STG + CW;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [31:0]       instruction;
  logic              stall;
  logic              flush;
  logic [1:0]        wb_sel;
  logic              regWEn;
  logic [4:0]        wb_rd;
  logic [STG-1:0]    hz_we;
  logic [5*STG-1:0]  hz_rd;
  logic [STG-1:0]    hz_load;
  logic [CW-1:0]     retired;

  int passed = 0;
  int total  = 0;

  wb_ctl_pipe #(.STAGES(STG), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
    .stall(stall), .flush(flush), .wb_sel(wb_sel), .regWEn(regWEn),
    .wb_rd(wb_rd), .hz_we(hz_we), .hz_rd(hz_rd), .hz_load(hz_load),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [OW-1:0] obs_main;
  assign obs_main = {wb_sel, regWEn, wb_rd, hz_we, hz_load, retired};

  // ---------------- reference model ----------------
  typedef struct {
    bit       v;
    bit       we;
    bit       ld;
    bit [1:0] sel;
    bit [4:0] rd;
    bit       known;
  } rec_t;

  rec_t        pipe_q[$];   // index 0 = youngest stage
  int unsigned ret_cnt;

  function automatic rec_t decode_ref(input bit vld, input logic [31:0] ins);
    rec_t r;
    bit [6:0] op;
    op = ins[6:0];
    r.v = vld; r.we = 0; r.ld = 0; r.sel = 2'b00; r.rd = ins[11:7]; r.known = 1;
    if (op inside {7'h37, 7'h17, 7'h13, 7'h33}) begin r.we = 1; r.sel = 2'b01; end
    else if (op inside {7'h6F, 7'h67}) begin r.we = 1; r.sel = 2'b10; end
    else if (op == 7'h03) begin r.we = 1; r.ld = 1; end
    if (r.rd == 0) r.we = 0;
    return r;
  endfunction

  task automatic model_reset();
    rec_t z;
    z.v = 0; z.we = 0; z.ld = 0; z.sel = 0; z.rd = 0; z.known = 1;
    pipe_q.delete();
    for (int i = 0; i < STG; i++) pipe_q.push_back(z);
    ret_cnt = 0;
  endtask

  task automatic model_edge();
    if (!stall) begin
      if (pipe_q[STG-1].v) ret_cnt++;
      void'(pipe_q.pop_back());
      pipe_q.push_front(decode_ref(in_valid, instruction));
    end
    if (flush) for (int i = 0; i < FD; i++) begin
      pipe_q[i].v = 0;
      pipe_q[i].known = 0;
    end
  endtask

  function automatic logic [OW-1:0] exp_main();
    rec_t f;
    logic [STG-1:0] web, ldb;
    f = pipe_q[STG-1];
    for (int i = 0; i < STG; i++) begin
      web[i] = pipe_q[i].v & pipe_q[i].we;
      ldb[i] = pipe_q[i].v & pipe_q[i].ld;
    end
    return {(f.v ? f.sel : 2'b00), (f.v & f.we), (f.v ? f.rd : 5'd0), web, ldb, CW'(ret_cnt)};
  endfunction

  function automatic logic [5*STG-1:0] exp_hzrd();
    logic [5*STG-1:0] r;
    for (int i = 0; i < STG; i++) r[5*i +: 5] = pipe_q[i].rd;
    return r;
  endfunction

  function automatic logic [5*STG-1:0] rd_mask();
    logic [5*STG-1:0] m;
    for (int i = 0; i < STG; i++) m[5*i +: 5] = pipe_q[i].known ? 5'h1F : 5'h00;
    return m;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h13;
      3: w[6:0] = 7'h33;
      4: w[6:0] = 7'h6F;
      5: w[6:0] = 7'h67;
      6: w[6:0] = 7'h03;
      7: w[6:0] = 7'h23;
      8: w[6:0] = 7'h63;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    in_valid = v; instruction = ins; stall = st; flush = fl;
    model_edge();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; instruction = 32'h00500293; stall = 1'b0; flush = 1'b0;
    model_reset();
    #12;
    total++;
    if (obs_main !== '0 || hz_rd !== '0)
      $display("FAIL reset_state got=%h/%h exp=0/0", obs_main, hz_rd);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      total++;
      if (obs_main !== exp_main())
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs_main, exp_main());
      else passed++;
    end
  endtask

  task automatic test_addi();
    for (int k = 0; k < 6; k++) begin
      cycle(k == 0, (k == 0) ? 32'h00500293 : 32'h0, 1'b0, 1'b0);
      total++;
      if (obs_main !== exp_main())
        $display("FAIL addi_model cyc=%0d got=%h exp=%h", k, obs_main, exp_main());
      else passed++;
      if (k == 2) begin
        total++;
        if ({regWEn, wb_sel, wb_rd} !== {1'b1, 2'b01, 5'd5})
          $display("FAIL addi_wb got=%b/%b/%0d exp=1/01/5", regWEn, wb_sel, wb_rd);
        else passed++;
      end
      if (k == 3) begin
        total++;
        if (retired !== CW'(1) || regWEn !== 1'b0)
          $display("FAIL addi_retire got=%0d/%b exp=1/0", retired, regWEn);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [5];
    logic [2:0]  exp_seq [5];
    seq[0] = 32'h00002083; seq[1] = 32'h0000016F; seq[2] = 32'h00002023;
    seq[3] = 32'h00000063; seq[4] = 32'h00000037;
    exp_seq[0] = 3'b100; exp_seq[1] = 3'b110; exp_seq[2] = 3'b000;
    exp_seq[3] = 3'b000; exp_seq[4] = 3'b001;
    for (int k = 0; k < 9; k++) begin
      cycle(k < 5, (k < 5) ? seq[k] : 32'h0, 1'b0, 1'b0);
      total++;
      if (obs_main !== exp_main())
        $display("FAIL b2b_model cyc=%0d got=%h exp=%h", k, obs_main, exp_main());
      else passed++;
      if (k == 0) begin
        total++;
        if (hz_load !== 3'b001) $display("FAIL b2b_hz_load got=%b exp=001", hz_load);
        else passed++;
      end
      if (k >= 2 && k <= 6) begin
        total++;
        if ({regWEn, wb_sel} !== exp_seq[k-2])
          $display("FAIL b2b_seq idx=%0d got=%b exp=%b", k-2, {regWEn, wb_sel}, exp_seq[k-2]);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    for (int k = 1; k <= 10; k++) begin
      w = 32'h00000013 | (32'($urandom_range(1, 31)) << 7);
      if (k == 1) cycle(1'b1, 32'h002081B3, 1'b0, 1'b0);
      else if (k <= 5) cycle(1'b1, w, 1'b1, 1'b0);
      else cycle(1'b0, w, 1'b0, 1'b0);
      total++;
      if (obs_main !== exp_main())
        $display("FAIL stall_model cyc=%0d got=%h exp=%h", k, obs_main, exp_main());
      else passed++;
      total++;
      if ((hz_rd & rd_mask()) !== (exp_hzrd() & rd_mask()))
        $display("FAIL stall_hz_rd cyc=%0d got=%h exp=%h", k, hz_rd, exp_hzrd());
      else passed++;
      total++;
      if (regWEn !== (k == 7) || (k == 7 && wb_rd !== 5'd3))
        $display("FAIL stall_arrival edge=%0d got=%b/%0d exp=%b/3", k, regWEn, wb_rd, k == 7);
      else passed++;
    end
  endtask

  task automatic test_flush();
    int unsigned r0;
    r0 = ret_cnt;
    // x7, x8 issued, x9 arrives together with flush
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: cycle(1'b1, 32'h00000393, 1'b0, 1'b0);
        1: cycle(1'b1, 32'h00000413, 1'b0, 1'b0);
        2: cycle(1'b1, 32'h00000493, 1'b0, 1'b1);
        default: cycle(1'b0, 32'h0, 1'b0, 1'b0);
      endcase
      total++;
      if (obs_main !== exp_main())
        $display("FAIL flush_model cyc=%0d got=%h exp=%h", k, obs_main, exp_main());
      else passed++;
      if (k >= 2) begin
        total++;
        if (regWEn !== (k == 2) || (k == 2 && wb_rd !== 5'd7))
          $display("FAIL flush_wb cyc=%0d got=%b/%0d exp=%b/7", k, regWEn, wb_rd, k == 2);
        else passed++;
      end
    end
    total++;
    if (retired !== CW'(r0 + 1)) $display("FAIL flush_retired got=%0d exp=%0d", retired, CW'(r0 + 1));
    else passed++;
    // x7, x8, x9 fill all stages, then flush while stalled
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: cycle(1'b1, 32'h00000393, 1'b0, 1'b0);
        1: cycle(1'b1, 32'h00000413, 1'b0, 1'b0);
        2: cycle(1'b1, 32'h00000493, 1'b0, 1'b0);
        3: cycle(1'b1, rand_ins(), 1'b1, 1'b1);
        default: cycle(1'b0, 32'h0, 1'b0, 1'b0);
      endcase
      total++;
      if (obs_main !== exp_main())
        $display("FAIL flush_stall_model cyc=%0d got=%h exp=%h", k, obs_main, exp_main());
      else passed++;
      if (k == 3) begin
        total++;
        if ({regWEn, wb_rd, hz_we} !== {1'b1, 5'd7, 3'b100})
          $display("FAIL flush_stall_hold got=%b/%0d/%b exp=1/7/100", regWEn, wb_rd, hz_we);
        else passed++;
      end
      if (k >= 4) begin
        total++;
        if (regWEn !== 1'b0) $display("FAIL flush_stall_after cyc=%0d got=%b exp=0", k, regWEn);
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 32'h00000393, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000413, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000493, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (obs_main !== '0 || hz_rd !== '0)
      $display("FAIL async_reset got=%h/%h exp=0/0", obs_main, hz_rd);
    else passed++;
    model_reset();
    in_valid = 1'b1; instruction = 32'h00000393;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (obs_main !== '0) $display("FAIL async_reset_hold got=%h exp=0", obs_main);
    else passed++;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      total++;
      if (obs_main !== exp_main() || regWEn !== 1'b0)
        $display("FAIL async_release cyc=%0d got=%h exp=%h", k, obs_main, exp_main());
      else passed++;
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 20; k++) begin
      cycle(k < 17, rand_ins(), 1'b0, 1'b0);
      total++;
      if (obs_main !== exp_main())
        $display("FAIL wrap_model cyc=%0d got=%h exp=%h", k, obs_main, exp_main());
      else passed++;
    end
    total++;
    if (retired !== CW'(1)) $display("FAIL wrap_retired got=%0d exp=1", retired);
    else passed++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, rand_ins(),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      total++;
      if (obs_main !== exp_main())
        $display("FAIL random_model cyc=%0d got=%h exp=%h", k, obs_main, exp_main());
      else passed++;
      total++;
      if ((hz_rd & rd_mask()) !== (exp_hzrd() & rd_mask()))
        $display("FAIL random_hz_rd cyc=%0d got=%h exp=%h", k, hz_rd, exp_hzrd() & rd_mask());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_ctl_pipe.md
# wb_ctl_pipe

Parametrised writeback-control pipeline for the rv32 core. It decodes the write-back source and register-write enable from each issued instruction and carries them, with `rd`, through `STAGES` pipeline registers to the register-file write port. It adds what a single-register decode lacks: valid tracking, stall and flush, x0 write suppression, JAL support, per-stage hazard taps for the forwarding and load-use logic, and a retired-instruction counter.

## Interface
- `STAGES`, 3, number of pipeline registers between issue and write-back (EX, MEM, WB); legal range 1..8.
- `FLUSH_DEPTH`, 2, number of youngest stages (stage 0 .. FLUSH_DEPTH-1) cleared by `flush`; legal range 0..STAGES.
- `CNT_W`, 32, width of the retired-instruction counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `instruction` is valid this cycle.
- `instruction`  in  32  RV32I instruction word being issued.
- `stall`  in  1  freeze every stage; no advance and no capture.
- `flush`  in  1  kill the stages 0..FLUSH_DEPTH-1.
- `wb_sel`  out  2  write-back source at the final stage: 00 memory, 01 ALU, 10 PC+4.
- `regWEn`  out  1  register-file write enable at the final stage.
- `wb_rd`  out  5  destination register at the final stage.
- `hz_we`  out  STAGES  per-stage bit: stage holds a valid writing instruction. Bit 0 is the youngest stage.
- `hz_rd`  out  5*STAGES  per-stage `rd`. Stage i occupies bits [5i+4:5i].
- `hz_load`  out  STAGES  per-stage bit: stage holds a valid load.
- `retired`  out  CNT_W  count of instructions that have left the final stage while valid.

## Operation
- Decode on `instruction[6:0]`, combinational at the input:
  - LUI 0110111, AUIPC 0010111, OP-IMM 0010011, OP 0110011: `we`=1, sel=01.
  - JAL 1101111, JALR 1100111: `we`=1, sel=10.
  - LOAD 0000011: `we`=1, sel=00, load=1.
  - STORE 0100011, BRANCH 1100011, and every other opcode: `we`=0, sel=00.
- `rd` = `instruction[11:7]`. If `rd`==0, `we` is forced to 0; sel and load are still carried.
- Each stage holds the tuple {valid, we, load, sel[1:0], rd[4:0]}.
- Advance when `stall`=0:
  - Stage 0 captures {`in_valid`, decode}.
  - Stage i captures stage i-1.
- Stall when `stall`=1: every stage holds its contents, and `instruction` is ignored.
- Flush when `flush`=1: the valid bit of stages 0..FLUSH_DEPTH-1 is cleared on this edge; other fields are don't-care. Stages FLUSH_DEPTH..STAGES-1 behave as normal.
- `flush` with `stall` both set:
  - Flushed stages are cleared.
  - Unflushed stages hold.
  - Nothing is captured from the input.
- `flush` without `stall`:
  - The pipe shifts first.
  - The incoming instruction is also killed when FLUSH_DEPTH ≥ 1.
- Outputs at the final stage (F = stage STAGES-1):
  - `regWEn` = valid & we.
  - `wb_sel` = sel if valid, else 00.
  - `wb_rd` = rd if valid, else 0.
- Hazard taps per stage i:
  - `hz_we[i]` = valid & we.
  - `hz_load[i]` = valid & load.
  - `hz_rd` carries `rd` unmasked.
- Retired counter:
  - Increments by 1 on each edge where `stall`=0 and stage F is valid.
  - Counts stores and branches as well.
  - Wraps modulo 2^CNT_W. Flush does not affect it.

## Timing
- Latency: an instruction issued with `in_valid`=1 at edge n, with no stall, appears on `wb_sel`/`regWEn`/`wb_rd` after edge n+STAGES-1. With STAGES=3 that is visible in the third cycle after issue.
- Each stalled cycle adds exactly one cycle of latency. Outputs stay constant while stalled.
- All outputs come from registers; there is no combinational path from inputs to outputs.
- Reset (`rst`=0), asynchronous, effective immediately:
  - Every stage's valid=0, we=0, load=0, sel=00, rd=0.
  - `retired`=0, `regWEn`=0, `wb_sel`=00, `wb_rd`=0, `hz_*`=0.
- Reset mid-operation discards all in-flight instructions.
- After release, the first capture happens on the first rising edge with `rst`=1.
- STAGES=1: stage 0 is also the final stage; a flush with FLUSH_DEPTH=1 kills that instruction before it writes back.

## Test plan
- Reset then ADDI x5 (0x00500293) issued once, STAGES=3: after the third edge `regWEn`=1, `wb_sel`=01, `wb_rd`=5 for one cycle; `retired`=1 one edge later.
- Back-to-back LW x1, JAL x2, SW, BEQ, LUI x0: final-stage sequence (regWEn, sel) is (1,00), (1,10), (0,00), (0,00), (0,01); `hz_load`=001 in the cycle after LW is issued.
- Issue ADD x3, hold `stall`=1 for 4 cycles while `instruction` changes: the output arrives 4 cycles late, `hz_rd` is frozen during the stall, and no extra instruction enters.
- Fill stages with x7, x8, x9 writers, pulse `flush` (FLUSH_DEPTH=2): only x7 writes back, `retired` advances by 1; repeat with `stall`=1 during the flush and check that the oldest stage holds.
- Assert `rst`=0 mid-cycle with 3 valid stages: outputs and `hz_*` clear without a clock edge, `retired`=0, and nothing writes back after release.
- CNT_W=4: retire 17 instructions; `retired` reads 1 after wrap.
